sti_dac_packer: RTL and testbench

//  Downstream of the serial transmitter. Deserialises the so_data/so_valid bit stream
//  (MSB-first per byte) into 8-bit pixels. Scatters each pixel into a 16x16

---
 rtl/sti_dac_packer_pkg.sv | 32 +++
 rtl/sti_dac_packer_bit_packer.sv | 40 ++++
 rtl/sti_dac_packer.sv | 111 +++++++++++
 tb/tb_sti_dac_packer.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sti_dac_packer_pkg.sv
// Shared constants, FSM encodings and the pixel-to-bank mapping helper for
// the STI DAC packer.
package sti_dac_packer_pkg;

  localparam int DW      = 8;
  localparam int BANK_AW = 5;
  localparam int NUM_PIX = 256;
  localparam int PIX_W   = $clog2(NUM_PIX);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RECV = 2'd1;
  localparam logic [1:0] FILL = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  // Picks out row[0] (bit 4) and col[0] (bit 0) of a 16x16 raster index.
  localparam logic [PIX_W-1:0] PARITY_MASK = PIX_W'('h11);

  typedef struct packed {
    logic       odd;
    logic [1:0] quarter;
  } bank_sel_t;

  // Checkerboard parity chooses odd/even banks; the top two index bits
  // choose which quarter of the frame (bank 1..4) the pixel lands in.
  function automatic bank_sel_t bank_sel(input logic [PIX_W-1:0] p);
    bank_sel_t s;
    s.odd     = ^(p & PARITY_MASK);
    s.quarter = 2'(p >> (PIX_W - 2));
    return s;
  endfunction

endpackage

// File: rtl/sti_dac_packer_bit_packer.sv
// Serial-to-parallel shifter: assembles MSB-first bits into DW-bit bytes and
// flags the edge on which the last bit of a byte is sampled.
module sti_bit_packer #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          clear,
  input  logic          so_data,
  input  logic          so_valid,
  output logic [DW-1:0] byte_data,
  output logic          byte_vld
);

  localparam int            CW   = $clog2(DW);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  logic [DW-2:0] shift;
  logic [CW-1:0] bit_cnt;

  // The incoming bit completes the byte combinationally so the top can
  // register the write on the same edge that samples the final bit.
  assign byte_data = {shift, so_data};
  assign byte_vld  = enable && so_valid && (bit_cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift   <= '0;
      bit_cnt <= '0;
    end else if (clear) begin
      shift   <= '0;
      bit_cnt <= '0;
    end else if (enable && so_valid) begin
      shift   <= byte_data[DW-2:0];
      bit_cnt <= (bit_cnt == LAST) ? '0 : bit_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sti_dac_packer.sv
// Packs the serial transmitter stream into pixels, scatters them over eight
// checkerboard-split banks, zero-fills the rest of the frame and signals finish.
module sti_dac_packer
  import sti_dac_packer_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               so_data,
  input  logic               so_valid,
  input  logic               pi_end,
  output logic [DW-1:0]      oem_dataout,
  output logic [BANK_AW-1:0] oem_addr,
  output logic               odd1_wr,
  output logic               odd2_wr,
  output logic               odd3_wr,
  output logic               odd4_wr,
  output logic               even1_wr,
  output logic               even2_wr,
  output logic               even3_wr,
  output logic               even4_wr,
  output logic               oem_finish
);

  localparam logic [PIX_W:0] PIX_FULL = (PIX_W + 1)'(NUM_PIX);

  logic [1:0]    state;
  logic [PIX_W:0] pix_cnt;
  logic [DW-1:0] byte_data;
  logic          byte_vld;
  logic          frame_full;
  logic          pack_en;
  logic          end_of_stream;
  logic          wr_req;
  logic [DW-1:0] wr_data;
  bank_sel_t     sel;
  logic [3:0]    odd_wr;
  logic [3:0]    even_wr;

  assign frame_full = (pix_cnt == PIX_FULL);
  assign pack_en    = ((state == IDLE) || (state == RECV)) && !frame_full;
  // Stream over: any bits of an unfinished byte are thrown away.
  assign end_of_stream = (state == RECV) && pi_end && !so_valid;
  assign sel = bank_sel(pix_cnt[PIX_W-1:0]);

  sti_bit_packer #(.DW(DW)) u_bit_packer (
    .clk      (clk),
    .reset    (reset),
    .enable   (pack_en),
    .clear    (end_of_stream),
    .so_data  (so_data),
    .so_valid (so_valid),
    .byte_data(byte_data),
    .byte_vld (byte_vld)
  );

  always_comb begin
    wr_req  = 1'b0;
    wr_data = byte_data;
    case (state)
      IDLE, RECV: wr_req = byte_vld;
      FILL: begin
        wr_req  = !frame_full;
        wr_data = '0;
      end
      default: wr_req = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      pix_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (so_valid) state <= RECV;
        RECV: begin
          if (frame_full)         state <= DONE;
          else if (end_of_stream) state <= FILL;
        end
        FILL: if (frame_full) state <= DONE;
        default: state <= DONE;
      endcase
      if (wr_req) pix_cnt <= pix_cnt + 1'b1;
    end
  end

  // Strobes and finish last a single cycle; data/address hold between writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      oem_dataout <= '0;
      oem_addr    <= '0;
      odd_wr      <= '0;
      even_wr     <= '0;
      oem_finish  <= 1'b0;
    end else begin
      odd_wr     <= '0;
      even_wr    <= '0;
      oem_finish <= ((state == RECV) || (state == FILL)) && frame_full;
      if (wr_req) begin
        oem_dataout <= wr_data;
        oem_addr    <= pix_cnt[BANK_AW:1];
        if (sel.odd) odd_wr  <= 4'b0001 << sel.quarter;
        else         even_wr <= 4'b0001 << sel.quarter;
      end
    end
  end

  assign {odd4_wr, odd3_wr, odd2_wr, odd1_wr}     = odd_wr;
  assign {even4_wr, even3_wr, even2_wr, even1_wr} = even_wr;

endmodule

// File: tb/tb_sti_dac_packer.sv
// Self-checking bench for sti_dac_packer: a monitor logs every bank write and
// finish pulse, and a raster-arithmetic model supplies the expected frame.
module tb_sti_dac_packer;

  logic       clk = 1'b0;
  logic       reset;
  logic       so_data;
  logic       so_valid;
  logic       pi_end;
  logic [7:0] oem_dataout;
  logic [4:0] oem_addr;
  logic       odd1_wr, odd2_wr, odd3_wr, odd4_wr;
  logic       even1_wr, even2_wr, even3_wr, even4_wr;
  logic       oem_finish;

  sti_dac_packer dut (
    .clk        (clk),
    .reset      (reset),
    .so_data    (so_data),
    .so_valid   (so_valid),
    .pi_end     (pi_end),
    .oem_dataout(oem_dataout),
    .oem_addr   (oem_addr),
    .odd1_wr    (odd1_wr),
    .odd2_wr    (odd2_wr),
    .odd3_wr    (odd3_wr),
    .odd4_wr    (odd4_wr),
    .even1_wr   (even1_wr),
    .even2_wr   (even2_wr),
    .even3_wr   (even3_wr),
    .even4_wr   (even4_wr),
    .oem_finish (oem_finish)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  wire [7:0] wr_vec = {even4_wr, even3_wr, even2_wr, even1_wr,
                       odd4_wr, odd3_wr, odd2_wr, odd1_wr};

  // Write record layout: {odd, bank-1, addr, data}
  typedef struct {
    logic [15:0] rec;
    int          cyc;
  } wr_t;

  typedef struct {
    int   slot;
    logic odd;
    int   bank;
    int   addr;
  } map_vec_t;

  wr_t        wr_q[$];
  int         fin_q[$];
  int         byte_end_cyc[$];
  int         hold_err = 0;
  int         multi_err = 0;
  int         tests = 0;
  int         fails = 0;
  int         last_bit_cyc;
  logic [7:0] last_data;
  logic [4:0] last_addr;
  logic [7:0] frame_bytes[256];
  int         mon_n;
  logic       mon_odd;
  logic [1:0] mon_bank;

  // Monitor: logs strobes, checks one-hot and that data/address hold.
  always @(negedge clk) begin
    if (reset) begin
      last_data = '0;
      last_addr = '0;
    end else begin
      mon_n = $countones(wr_vec);
      if (mon_n > 1) multi_err++;
      if (mon_n == 1) begin
        mon_odd  = 1'b0;
        mon_bank = 2'd0;
        for (int k = 0; k < 8; k++)
          if (wr_vec[k]) begin
            mon_odd  = (k < 4);
            mon_bank = 2'(k % 4);
          end
        wr_q.push_back('{{mon_odd, mon_bank, oem_addr, oem_dataout}, cyc});
        last_data = oem_dataout;
        last_addr = oem_addr;
      end else if (oem_dataout !== last_data || oem_addr !== last_addr) begin
        hold_err++;
      end
      if (oem_finish) fin_q.push_back(cyc);
    end
  end

  // Reference: slot p of a 16x16 raster, four 64-pixel quarters.
  function automatic logic [15:0] model_rec(input int p, input logic [7:0] d);
    int         row;
    int         col;
    logic       o;
    logic [1:0] bank;
    logic [4:0] addr;
    row  = p / 16;
    col  = p % 16;
    o    = (row % 2) != (col % 2);
    bank = 2'(p / 64);
    addr = 5'((p % 64) / 2);
    return {o, bank, addr, d};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got,
                             input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    so_valid = 1'b0;
    so_data  = 1'b0;
    pi_end   = 1'b0;
    reset    = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    wr_q.delete();
    fin_q.delete();
    byte_end_cyc.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    so_data  = b;
    so_valid = 1'b1;
    @(posedge clk);
    #1 so_valid = 1'b0;
    last_bit_cyc = cyc;
  endtask

  task automatic send_byte(input logic [7:0] d, input int max_gap);
    for (int i = 7; i >= 0; i--) begin
      send_bit(d[i]);
      if (max_gap > 0)
        repeat ($urandom_range(max_gap, 0)) begin
          @(posedge clk);
          #1;
        end
    end
    byte_end_cyc.push_back(last_bit_cyc);
  endtask

  task automatic wait_finish(input string name);
    int t = 0;
    while (fin_q.size() == 0 && t < 2000) begin
      @(posedge clk);
      #1 t++;
    end
    checkOutput({name, " finish seen"}, 32'(fin_q.size() > 0), 1);
    repeat (6) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input string name, input int n, input int max_gap,
                               input int stray, input bit early_end);
    for (int b = 0; b < n; b++) begin
      if (early_end && b == n - 1) pi_end = 1'b1;
      send_byte(frame_bytes[b], max_gap);
    end
    for (int s = 0; s < stray; s++) send_bit(1'($urandom));
    if (n < 256) pi_end = 1'b1;
    wait_finish(name);
  endtask

  task automatic check_frame(input string name, input int n_data);
    int          bad = 0;
    int          first = -1;
    int          lat_bad = 0;
    int          gap_bad = 0;
    logic [15:0] exp;
    checkOutput({name, " write count"}, wr_q.size(), 256);
    for (int p = 0; p < wr_q.size() && p < 256; p++) begin
      exp = model_rec(p, (p < n_data) ? frame_bytes[p] : 8'h00);
      if (wr_q[p].rec !== exp) begin
        bad++;
        if (first < 0) first = p;
      end
    end
    checkOutput({name, " bad slots"}, bad, 0);
    if (first >= 0)
      checkOutput({name, " first bad slot"}, wr_q[first].rec,
                  model_rec(first, (first < n_data) ? frame_bytes[first] : 8'h00));
    for (int b = 0; b < byte_end_cyc.size() && b < wr_q.size(); b++)
      if (wr_q[b].cyc != byte_end_cyc[b]) lat_bad++;
    checkOutput({name, " strobe latency errors"}, lat_bad, 0);
    for (int p = n_data + 1; p < wr_q.size() && p < 256; p++)
      if (wr_q[p].cyc != wr_q[p-1].cyc + 1) gap_bad++;
    checkOutput({name, " fill gaps"}, gap_bad, 0);
    checkOutput({name, " finish count"}, fin_q.size(), 1);
    if (fin_q.size() > 0 && wr_q.size() > 0)
      checkOutput({name, " finish timing"}, fin_q[0], wr_q[wr_q.size()-1].cyc + 1);
  endtask

  map_vec_t    map_tbl[9];
  logic [15:0] ref_recs[$];
  int          diff;
  int          t;

  initial begin
    // Mapping vectors for the value=index frame: slot, odd, bank, addr.
    map_tbl[0] = '{0,   1'b0, 1, 0};
    map_tbl[1] = '{1,   1'b1, 1, 0};
    map_tbl[2] = '{16,  1'b1, 1, 8};
    map_tbl[3] = '{17,  1'b0, 1, 8};
    map_tbl[4] = '{64,  1'b0, 2, 0};
    map_tbl[5] = '{77,  1'b1, 2, 6};
    map_tbl[6] = '{130, 1'b0, 3, 1};
    map_tbl[7] = '{200, 1'b0, 4, 4};
    map_tbl[8] = '{255, 1'b0, 4, 31};

    reset    = 1'b1;
    so_valid = 1'b0;
    so_data  = 1'b0;
    pi_end   = 1'b0;
    #3;
    checkOutput("reset outputs", {oem_dataout, oem_addr, wr_vec, oem_finish}, 0);

    // One 16-bit word 0xA53C, gap-free
    do_reset();
    frame_bytes[0] = 8'hA5;
    frame_bytes[1] = 8'h3C;
    applyStimulus("t1", 2, 0, 0, 1'b0);
    if (wr_q.size() >= 2) begin
      checkOutput("t1 p0 even1 addr0", wr_q[0].rec, 16'h00A5);
      checkOutput("t1 p1 odd1 addr0", wr_q[1].rec, 16'h803C);
    end else begin
      checkOutput("t1 early writes", wr_q.size(), 2);
    end
    check_frame("t1", 2);

    // Full frame, value = index, pi_end low
    do_reset();
    for (int i = 0; i < 256; i++) frame_bytes[i] = 8'(i);
    applyStimulus("t2", 256, 0, 0, 1'b0);
    check_frame("t2", 256);
    foreach (map_tbl[i]) begin
      if (map_tbl[i].slot < wr_q.size())
        checkOutput($sformatf("t2 map slot %0d", map_tbl[i].slot),
                    wr_q[map_tbl[i].slot].rec,
                    {map_tbl[i].odd, 2'(map_tbl[i].bank - 1),
                     5'(map_tbl[i].addr), 8'(map_tbl[i].slot)});
    end

    // Full random frame with pi_end already high on the last byte
    do_reset();
    for (int i = 0; i < 256; i++) frame_bytes[i] = 8'($urandom);
    applyStimulus("t2b", 256, 0, 0, 1'b1);
    check_frame("t2b", 256);

    // 24 bytes then pi_end: zero fill of slots 24..255
    do_reset();
    for (int i = 0; i < 24; i++) frame_bytes[i] = 8'($urandom);
    applyStimulus("t3", 24, 0, 0, 1'b0);
    check_frame("t3", 24);

    // Gaps inside bytes must not change pixels or addresses
    do_reset();
    for (int i = 0; i < 40; i++) frame_bytes[i] = 8'($urandom);
    applyStimulus("t4 nogap", 40, 0, 0, 1'b0);
    check_frame("t4 nogap", 40);
    ref_recs.delete();
    foreach (wr_q[i]) ref_recs.push_back(wr_q[i].rec);
    do_reset();
    applyStimulus("t4 gaps", 40, 5, 0, 1'b0);
    check_frame("t4 gaps", 40);
    diff = 0;
    for (int i = 0; i < wr_q.size() && i < ref_recs.size(); i++)
      if (wr_q[i].rec !== ref_recs[i]) diff++;
    checkOutput("t4 gap vs gap-free diffs", diff, 0);

    // Five stray bits before pi_end are discarded
    do_reset();
    for (int i = 0; i < 10; i++) frame_bytes[i] = 8'($urandom_range(255, 1));
    applyStimulus("t5", 10, 0, 5, 1'b0);
    check_frame("t5", 10);

    // Asynchronous reset mid-byte
    do_reset();
    frame_bytes[0] = 8'h11;
    frame_bytes[1] = 8'h22;
    frame_bytes[2] = 8'h33;
    for (int b = 0; b < 3; b++) send_byte(frame_bytes[b], 0);
    for (int s = 0; s < 3; s++) send_bit(1'b1);
    checkOutput("t6 pre-reset dataout", oem_dataout, 8'h33);
    reset = 1'b1;
    #1;
    checkOutput("t6 mid-byte reset outputs",
                {oem_dataout, oem_addr, wr_vec, oem_finish}, 0);

    // Asynchronous reset mid-fill, strobe high at the time
    do_reset();
    for (int b = 0; b < 5; b++) send_byte(8'($urandom), 0);
    pi_end = 1'b1;
    t = 0;
    while (wr_q.size() < 12 && t < 600) begin
      @(posedge clk);
      #1 t++;
    end
    @(posedge clk);
    #1;
    checkOutput("t6 pre-reset fill strobe", 32'(wr_vec != 8'h00), 1);
    reset = 1'b1;
    #1;
    checkOutput("t6 mid-fill reset outputs",
                {oem_dataout, oem_addr, wr_vec, oem_finish}, 0);

    // Fresh frame after reset starts at slot 0
    do_reset();
    frame_bytes[0] = 8'h5A;
    frame_bytes[1] = 8'hC3;
    applyStimulus("t6 fresh", 2, 0, 0, 1'b0);
    if (wr_q.size() > 0) checkOutput("t6 fresh p0 even1 addr0", wr_q[0].rec, 16'h005A);
    check_frame("t6 fresh", 2);

    checkOutput("one-hot strobe violations", multi_err, 0);
    checkOutput("data/addr hold violations", hold_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
